fifo_rd_arb: RTL and testbench
==============================

# fifo_rd_arb

Round-robin read scheduler that drains up to CH_N first-word-fall-through `fifo` read ports into one shared output stream. Each grant allows a bounded burst of up to BURST words. The output is a single registered stage with a valid/ready handshake, and each word is tagged with its source channel. It sits between per-source FIFOs, such as peripheral RX queues, and a single consumer such as a register-bus readout or a serializer.

## Interface
Parameters:
- CH_N, 4, number of FIFO channels (2..16)
- DATA_W, 9, word width; must match the connected FIFOs
- BURST, 4, maximum words popped per grant (≥1)
- CH_W, $clog2(CH_N), channel index width (derived localparam)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active low
- ch_data_i  in  CH_N×DATA_W  head word of each FIFO (FWFT `rd_data_o`); channel k occupies bits [k*DATA_W +: DATA_W]
- ch_rdy_i  in  CH_N  FIFO `rd_rdy_o` per channel
- ch_rd_o  out  CH_N  pop strobe to FIFO `rd_i`, one-hot or zero
- ch_en_i  in  CH_N  per-channel enable mask (configuration)
- out_data_o  out  DATA_W  registered output word
- out_ch_o  out  CH_W  source channel of out_data_o
- out_vld_o  out  1  output word valid
- out_rdy_i  in  1  consumer accepts the word while out_vld_o=1

## Operation
- Connected FIFOs must present a same-cycle `rd_rdy_o`, which means REG_OUT=0. Otherwise they must use PROT_RD=1.
- State registers:
  - state ∈ {IDLE, GRANT}
  - grant (CH_W bits)
  - last (CH_W bits)
  - cnt (width $clog2(BURST), min 1)
- Eligibility: `elig[k] = ch_rdy_i[k] & ch_en_i[k]`.
- IDLE:
  - Search elig starting at index last+1, wrapping modulo CH_N.
  - On the first hit, register grant=hit and last=hit, clear cnt, and go to GRANT.
  - If there is no hit, stay in IDLE.
- Space condition: `space = !out_vld_o | out_rdy_i`.
- Pop: `pop = (state==GRANT) & elig[grant] & space`. The pop drives `ch_rd_o[grant]=1`, with all other bits 0.
- On pop:
  - out_data_o ← ch_data_i[grant]
  - out_ch_o ← grant
  - out_vld_o ← 1
  - cnt ← cnt+1
- When out_vld_o & out_rdy_i and there is no pop: out_vld_o ← 0. out_data_o and out_ch_o hold their values.
- GRANT exits to IDLE when either condition holds:
  - a pop occurs with cnt==BURST-1 (burst complete);
  - elig[grant]=0 (channel empty or disabled). No pop occurs that cycle.
- GRANT stays in GRANT while elig[grant]=1 and space=0 (backpressure). cnt holds in that case.
- Fairness: the next search always starts after the last granted channel. No channel waits more than CH_N-1 grants.
- Clearing ch_en_i[k] mid-burst ends the burst. A word already registered at the output is still delivered.

## Timing
- Reset values (async assert, synchronous release edge):
  - state=IDLE, last=CH_N-1 (channel 0 is searched first), grant=0, cnt=0
  - out_vld_o=0, out_data_o=0, out_ch_o=0
  - ch_rd_o=0 (combinational from state)
- Arbitration costs one IDLE cycle per grant. The first pop occurs in the first GRANT cycle.
- Latency: out_vld_o rises 1 cycle after the pop. The full path from ch_rdy_i rising while IDLE to out_vld_o is 2 cycles.
- Throughput within a burst: 1 word/cycle when out_rdy_i=1. Sustained rate is BURST/(BURST+1) with a continuously full channel.
- ch_rd_o is combinational from state, ch_rdy_i, ch_en_i and out_rdy_i. The FIFO head updates the cycle after a pop.
- Simultaneous consume and pop: the output register reloads, so out_vld_o stays 1 with no bubble.
- Reset mid-burst: the output is dropped and out_vld_o is cleared immediately. Any word already popped is lost; this is intended.

## Test plan
- Reset, then ch_rdy_i=0001 with 3 words, out_rdy_i=1, BURST=4 → ch_rd_o[0] pulses 3 consecutive cycles. out_vld_o is high for 3 cycles starting 2 cycles after release, with out_ch_o=0. Then IDLE.
- Channels 0 and 2 each hold 5 words, BURST=2 → output channel order 0,0,2,2,0,0,2,2,0,2. One idle gap precedes each new grant.
- Hold out_rdy_i=0 for 4 cycles mid-burst → exactly one pop before the stall, and out_data_o/out_ch_o hold stable. Resuming gives 1 word/cycle with no duplicates or drops.
- ch_en_i=1011 with all channels non-empty → channel 2 is never popped. Clearing ch_en_i[1] mid-burst gives no further pops of channel 1 from the next cycle.
- Assert rst_n_i low mid-burst → out_vld_o=0 and ch_rd_o=0 in the same cycle. After release, arbitration restarts at channel 0.
- Channel 3 goes empty at cnt=1 with BURST=4 → exit to IDLE, and the grant passes to the next eligible channel after 3, wrapping to 0.

Source files
------------

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin read scheduler that drains several FWFT FIFO
// read ports into one registered valid/ready output stream. Each grant may
// pop up to BURST words; each output word carries its source channel index.
module fifo_rd_arb #(
    parameter  int unsigned CH_N   = 4,
    parameter  int unsigned DATA_W = 9,
    parameter  int unsigned BURST  = 4,
    localparam int unsigned CH_W   = $clog2(CH_N)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [CH_N*DATA_W-1:0]   ch_data_i,
    input  logic [CH_N-1:0]          ch_rdy_i,
    output logic [CH_N-1:0]          ch_rd_o,
    input  logic [CH_N-1:0]          ch_en_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_ch_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i
);

    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        r_state;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_vld;

    logic [0:0]        w_state_nxt;
    logic [CH_W-1:0]   w_grant_nxt;
    logic [CH_W-1:0]   w_last_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic [CH_W-1:0]   w_out_ch_nxt;
    logic              w_out_vld_nxt;

    logic [CH_N-1:0]   w_elig;
    logic              w_space;
    logic              w_grant_elig;
    logic              w_pop;
    logic              w_hit_found;
    logic [CH_W-1:0]   w_hit;
    logic [CH_W-1:0]   w_idx;
    logic [DATA_W-1:0] w_ch_data [CH_N];

    // Split the flat data bus into one word per channel
    for (genvar g = 0; g < CH_N; g++) begin : g_unpack
        assign w_ch_data[g] = ch_data_i[g*DATA_W +: DATA_W];
    end

    assign w_elig       = ch_rdy_i & ch_en_i;
    assign w_space      = !r_out_vld | out_rdy_i;
    assign w_grant_elig = w_elig[r_grant];
    assign w_pop        = (r_state == S_GRANT) & w_grant_elig & w_space;

    // Round-robin search: first eligible channel after the last granted one
    always_comb begin
        w_hit_found = 1'b0;
        w_hit       = '0;
        w_idx       = '0;
        for (int unsigned i = 1; i <= CH_N; i++) begin
            w_idx = CH_W'((32'(r_last) + i) % CH_N);
            if (!w_hit_found && w_elig[w_idx]) begin
                w_hit_found = 1'b1;
                w_hit       = w_idx;
            end
        end
    end

    // Pop strobe towards the granted FIFO, one-hot or zero
    always_comb begin
        ch_rd_o = '0;
        if (w_pop) begin
            ch_rd_o[r_grant] = 1'b1;
        end
    end

    // Next-state and output-register logic
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_out_data_nxt = r_out_data;
        w_out_ch_nxt   = r_out_ch;
        w_out_vld_nxt  = r_out_vld;

        case (r_state)
            S_IDLE: begin
                if (w_hit_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_hit;
                    w_last_nxt  = w_hit;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (!w_grant_elig) begin
                    // channel drained or disabled: give up the grant
                    w_state_nxt = S_IDLE;
                end else if (w_space) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BURST - 1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_pop) begin
            w_out_data_nxt = w_ch_data[r_grant];
            w_out_ch_nxt   = r_grant;
            w_out_vld_nxt  = 1'b1;
        end else if (r_out_vld && out_rdy_i) begin
            w_out_vld_nxt  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= CH_W'(CH_N - 1);
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_ch   <= w_out_ch_nxt;
            r_out_vld  <= w_out_vld_nxt;
        end
    end

    assign out_data_o = r_out_data;
    assign out_ch_o   = r_out_ch;
    assign out_vld_o  = r_out_vld;

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Testbench for fifo_rd_arb: FWFT FIFO models per channel, per-channel
// scoreboard filled at push time, negedge monitor checking every handshake.
module tb_fifo_rd_arb;

    localparam int unsigned CH_N   = 4;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned BURST  = 4;
    localparam int unsigned CH_W   = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b1;
    logic [CH_N*DATA_W-1:0] ch_data_i = '0;
    logic [CH_N-1:0]        ch_rdy_i = '0;
    logic [CH_N-1:0]        ch_rd_o;
    logic [CH_N-1:0]        ch_en_i = '1;
    logic [DATA_W-1:0]      out_data_o;
    logic [CH_W-1:0]        out_ch_o;
    logic                   out_vld_o;
    logic                   out_rdy_i = 1'b1;

    fifo_rd_arb #(.CH_N(CH_N), .DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ch_data_i  (ch_data_i),
        .ch_rdy_i   (ch_rdy_i),
        .ch_rd_o    (ch_rd_o),
        .ch_en_i    (ch_en_i),
        .out_data_o (out_data_o),
        .out_ch_o   (out_ch_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] fifo_q [CH_N][$];
    logic [DATA_W-1:0] exp_q  [CH_N][$];
    int                got_ch [$];
    logic [CH_N-1:0]   pend_pop = '0;

    // monitor state
    logic [CH_N-1:0] mon_el;
    logic            mon_sp;
    int              mon_c;
    int              run_ch = 0;
    int              run_len = 0;
    bit              amb = 1'b0;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic drive_fifo();
        for (int k = 0; k < CH_N; k++) begin
            ch_rdy_i[k] = (fifo_q[k].size() != 0);
            ch_data_i[k*DATA_W +: DATA_W] = ch_rdy_i[k] ? fifo_q[k][0] : '0;
        end
    endtask

    task automatic push(input int c, input int n);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = DATA_W'($urandom);
            fifo_q[c].push_back(w);
            exp_q[c].push_back(w);
        end
        drive_fifo();
    endtask

    // one clock: FIFO models consume the pops the DUT strobed before the edge
    task automatic tick();
        logic [CH_N-1:0] p;
        @(posedge clk_i);
        p = pend_pop;
        #1;
        if (rst_n_i) begin
            for (int k = 0; k < CH_N; k++)
                if (p[k] && fifo_q[k].size() != 0) void'(fifo_q[k].pop_front());
        end
        drive_fifo();
    endtask

    task automatic do_reset(input logic [CH_N-1:0] en, input int n0, input int n1,
                            input int n2, input int n3);
        rst_n_i   = 1'b0;
        out_rdy_i = 1'b1;
        ch_en_i   = en;
        for (int k = 0; k < CH_N; k++) begin
            fifo_q[k].delete();
            exp_q[k].delete();
        end
        got_ch.delete();
        push(0, n0); push(1, n1); push(2, n2); push(3, n3);
        #1;
        chk("rst_out_vld", out_vld_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_ch", out_ch_o, 0);
        chk("rst_ch_rd", ch_rd_o, 0);
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    // Monitor: pop legality, burst/arbitration-gap rules, scoreboard on handshake
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            pend_pop = '0;
            run_len  = 0;
            amb      = 1'b0;
        end else begin
            mon_el   = ch_rdy_i & ch_en_i;
            mon_sp   = !out_vld_o | out_rdy_i;
            pend_pop = ch_rd_o;
            if (ch_rd_o != '0) begin
                chk("rd_onehot", $countones(ch_rd_o), 1);
                chk("rd_only_eligible", int'(ch_rd_o & ~mon_el), 0);
                chk("rd_only_with_space", int'(mon_sp), 1);
                mon_c = 0;
                for (int k = CH_N - 1; k >= 0; k--) if (ch_rd_o[k]) mon_c = k;
                if (run_len == 0) begin
                    run_ch = mon_c; run_len = 1;
                end else if (mon_c != run_ch) begin
                    if (!amb) chk("arb_gap_before_new_grant", mon_c, run_ch);
                    run_ch = mon_c; run_len = 1;
                end else if (amb && run_len >= int'(BURST)) begin
                    run_len = 1;
                end else begin
                    run_len++;
                end
                chk("burst_len_within_limit", int'(run_len <= int'(BURST)), 1);
                amb = 1'b0;
            end else if (mon_sp || !mon_el[run_ch]) begin
                run_len = 0;
                amb     = 1'b0;
            end else begin
                amb = 1'b1;
            end
            if (out_vld_o && out_rdy_i) begin
                mon_c = int'(out_ch_o);
                got_ch.push_back(mon_c);
                if (exp_q[mon_c].size() == 0) chk("sb_word_available", 0, 1);
                else chk("sb_data", int'(out_data_o), int'(exp_q[mon_c].pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    logic [CH_N-1:0] t1_rd [6];
    logic            t1_vld [6];
    logic [CH_N-1:0] t2_rd [16];
    int              t2_ch [10];
    int              t6_ch [5];
    logic [DATA_W-1:0] w0;
    int              cnt_a;
    int              guard;
    logic            prev1;

    initial begin
        t1_rd  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        t1_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        t2_rd  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4,
                   4'h4, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
        t2_ch  = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 2};
        t6_ch  = '{3, 0, 0, 0, 2};
        #2;

        // single channel, 3 words: pop timing and output latency
        do_reset(4'b1111, 3, 0, 0, 0);
        for (int s = 0; s < 6; s++) begin
            tick();
            @(negedge clk_i);
            chk($sformatf("t1_rd[%0d]", s), ch_rd_o, t1_rd[s]);
            chk($sformatf("t1_vld[%0d]", s), out_vld_o, t1_vld[s]);
            if (out_vld_o) chk($sformatf("t1_ch[%0d]", s), out_ch_o, 0);
        end
        chk("t1_all_delivered", exp_q[0].size(), 0);

        // two channels with 5 words each: order and idle gaps
        do_reset(4'b1111, 5, 0, 5, 0);
        for (int s = 0; s < 16; s++) begin
            tick();
            @(negedge clk_i);
            chk($sformatf("t2_rd[%0d]", s), ch_rd_o, t2_rd[s]);
        end
        chk("t2_count", got_ch.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t2_order[%0d]", i), (i < got_ch.size()) ? got_ch[i] : -1, t2_ch[i]);

        // backpressure mid-burst
        do_reset(4'b1111, 0, 6, 0, 0);
        w0 = fifo_q[1][0];
        tick();
        @(negedge clk_i);
        chk("t3_first_rd", ch_rd_o, 4'h2);
        tick();
        out_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("t3_stall_vld[%0d]", i), out_vld_o, 1);
            chk($sformatf("t3_stall_ch[%0d]", i), out_ch_o, 1);
            chk($sformatf("t3_stall_data[%0d]", i), out_data_o, w0);
            chk($sformatf("t3_stall_rd[%0d]", i), ch_rd_o, 0);
            tick();
        end
        chk("t3_pops_before_stall", 6 - fifo_q[1].size(), 1);
        out_rdy_i = 1'b1;
        @(negedge clk_i);
        chk("t3_resume_rd", ch_rd_o, 4'h2);
        repeat (14) tick();
        chk("t3_no_drop_or_dup", exp_q[1].size(), 0);
        chk("t3_count", got_ch.size(), 6);

        // enable mask: channel 2 masked, then channel 1 cleared mid-burst
        do_reset(4'b1011, 16, 16, 16, 16);
        cnt_a = 0;
        repeat (40) begin
            tick();
            @(negedge clk_i);
            if (ch_rd_o[2]) cnt_a++;
        end
        chk("t4_ch2_never_popped", cnt_a, 0);
        guard = 0;
        prev1 = 1'b1;
        do begin
            prev1 = ch_rd_o[1];
            tick();
            @(negedge clk_i);
            guard++;
        end while (!(ch_rd_o[1] && !prev1) && guard < 100);
        chk("t4_ch1_burst_start_seen", ch_rd_o[1], 1);
        tick();
        ch_en_i[1] = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (ch_rd_o[1]) cnt_a++;
            tick();
        end
        chk("t4_ch1_no_pop_after_disable", cnt_a, 0);
        ch_en_i = 4'b1111;
        repeat (150) tick();
        for (int k = 0; k < CH_N; k++)
            chk($sformatf("t4_drained[%0d]", k), exp_q[k].size(), 0);

        // reset mid-burst, then arbitration restarts at channel 0
        do_reset(4'b1111, 0, 0, 6, 0);
        repeat (3) tick();
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t5_rst_vld_now", out_vld_o, 0);
        chk("t5_rst_rd_now", ch_rd_o, 0);
        do_reset(4'b1111, 2, 2, 2, 2);
        tick();
        @(negedge clk_i);
        chk("t5_restart_ch0", ch_rd_o, 4'h1);
        repeat (20) tick();
        chk("t5_first_out_ch", (got_ch.size() > 0) ? got_ch[0] : -1, 0);
        for (int k = 0; k < CH_N; k++)
            chk($sformatf("t5_drained[%0d]", k), exp_q[k].size(), 0);

        // channel 3 empties at cnt=1, grant wraps to channel 0
        do_reset(4'b1111, 0, 0, 0, 1);
        tick();
        @(negedge clk_i);
        chk("t6_grant_ch3", ch_rd_o, 4'h8);
        tick();
        push(0, 3);
        push(2, 3);
        @(negedge clk_i);
        chk("t6_empty_exit", ch_rd_o, 0);
        tick();
        @(negedge clk_i);
        chk("t6_idle", ch_rd_o, 0);
        tick();
        @(negedge clk_i);
        chk("t6_wrap_to_ch0", ch_rd_o, 4'h1);
        repeat (20) tick();
        for (int i = 0; i < 5; i++)
            chk($sformatf("t6_order[%0d]", i), (i < got_ch.size()) ? got_ch[i] : -1, t6_ch[i]);

        // randomized traffic, backpressure and enable changes
        do_reset(4'b1111, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int k = 0; k < CH_N; k++)
                if ($urandom_range(0, 3) == 0 && fifo_q[k].size() < 16) push(k, 1);
            out_rdy_i = ($urandom_range(0, 3) != 0);
            if (cyc % 64 == 63) ch_en_i = CH_N'($urandom);
        end
        ch_en_i   = 4'b1111;
        out_rdy_i = 1'b1;
        guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && guard < 2000) begin
            tick();
            guard++;
        end
        for (int k = 0; k < CH_N; k++)
            chk($sformatf("rnd_drained[%0d]", k), exp_q[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
